// File: rtl/beam_trig_pkg.sv
`default_nettype none
// ============================================================================
// Module      : beam_trig_pkg
// Description : Shared constants and the sequencer state encoding for the
//               beamformer trigger threshold-load path.
//               c_THRESH_W       - default threshold width
//               c_DEFAULT_THRESH - value every shadow threshold resets to
//               beam_seq_state_e - IDLE / LOAD / UPDATE / DONE
// Revision    : 1.0 - initial release
// ============================================================================
package beam_trig_pkg;

  localparam int unsigned c_THRESH_W       = 18;
  localparam int unsigned c_DEFAULT_THRESH = 9000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } beam_seq_state_e;

endpackage : beam_trig_pkg
`default_nettype wire

// File: rtl/prio_onehot_enc.sv
`default_nettype none
// ============================================================================
// Module      : prio_onehot_enc
// Description : Lowest-set-bit priority encoder.
//               req_i    - request vector
//               idx_o    - index of the lowest set bit (0 when none set)
//               onehot_o - the lowest set bit isolated as a one-hot vector
//               valid_o  - at least one request bit is set
// Revision    : 1.0 - initial release
// ============================================================================
module prio_onehot_enc #(
  parameter int unsigned NBEAMS = 8,
  parameter int unsigned IDX_W  = (NBEAMS > 1) ? $clog2(NBEAMS) : 1
) (
  input  logic [NBEAMS-1:0] req_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic [NBEAMS-1:0] onehot_o,
  output logic              valid_o
);

  // Scan from the top down so the lowest set bit is the last to assign.
  always_comb begin
    idx_o = '0;
    for (int i = NBEAMS - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IDX_W'(i);
      end
    end
  end

  // Two's-complement trick: x & -x keeps only the lowest set bit.
  assign onehot_o = req_i & (~req_i + NBEAMS'(1));
  assign valid_o  = |req_i;

endmodule : prio_onehot_enc
`default_nettype wire

// File: rtl/beam_threshold_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : beam_threshold_sequencer
// Description : Keeps a shadow bank of per-beam thresholds and, on an apply,
//               streams only the changed ones into the beamformer (one beam
//               per cycle, one-hot load enable) followed by a single commit
//               pulse so all new thresholds take effect together.
// Ports       : clk_i        - system clock
//               rst_ni       - asynchronous active-low reset
//               wr_valid_i   - shadow write strobe
//               wr_beam_i    - beam index for the write
//               wr_data_i    - threshold value to write
//               apply_req_i  - level request to push dirty thresholds
//               apply_ack_o  - one-cycle pulse: request accepted
//               busy_o       - sequence in progress
//               done_o       - one-cycle pulse the cycle after update_o
//               dirty_o      - beams written but not yet applied
//               thresh_o     - threshold value to the beamformer
//               thresh_ce_o  - one-hot per-beam load enable
//               update_o     - commit pulse to the beamformer
// Revision    : 1.0 - initial release
// ============================================================================
module beam_threshold_sequencer
  import beam_trig_pkg::*;
#(
  parameter int unsigned NBEAMS         = 8,
  parameter int unsigned THRESH_W       = c_THRESH_W,
  parameter int unsigned DEFAULT_THRESH = c_DEFAULT_THRESH,
  parameter bit          AUTO_INIT      = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wr_valid_i,
  input  logic [$clog2(NBEAMS)-1:0] wr_beam_i,
  input  logic [THRESH_W-1:0]       wr_data_i,
  input  logic                      apply_req_i,
  output logic                      apply_ack_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [NBEAMS-1:0]         dirty_o,
  output logic [THRESH_W-1:0]       thresh_o,
  output logic [NBEAMS-1:0]         thresh_ce_o,
  output logic                      update_o
);

  localparam int unsigned c_BEAM_W = $clog2(NBEAMS);

  beam_seq_state_e     r_state;
  logic [THRESH_W-1:0] r_shadow [NBEAMS];
  logic [NBEAMS-1:0]   r_dirty;
  logic [NBEAMS-1:0]   r_work;
  logic                r_init_pending;
  logic                r_apply_ack;
  logic                r_busy;
  logic                r_done;
  logic                r_update;
  logic [THRESH_W-1:0] r_thresh;
  logic [NBEAMS-1:0]   r_thresh_ce;

  logic                w_wr_in_range;
  logic                w_wr_hit;
  logic [NBEAMS-1:0]   w_wr_set;
  logic                w_take;
  logic [NBEAMS-1:0]   w_dirty_next;
  logic [c_BEAM_W-1:0] w_idx;
  logic [NBEAMS-1:0]   w_onehot;
  logic                w_valid;
  logic [NBEAMS-1:0]   w_work_rem;

  // With a power-of-two beam count every encodable index is a real beam.
  generate
    if ((1 << c_BEAM_W) == NBEAMS) begin : g_full_range
      assign w_wr_in_range = 1'b1;
    end else begin : g_part_range
      assign w_wr_in_range = (32'(wr_beam_i) < NBEAMS);
    end
  endgenerate

  assign w_wr_hit = wr_valid_i & w_wr_in_range;
  assign w_wr_set = w_wr_hit ? (NBEAMS'(1) << wr_beam_i) : '0;

  // The auto-init apply is a one-shot on the first cycle out of reset.
  assign w_take = (r_state == IDLE) && (apply_req_i || r_init_pending);

  // Snapshot clears the pending bits, but a write landing on the same edge
  // must survive so it is picked up by the next apply.
  assign w_dirty_next = w_take ? w_wr_set : (r_dirty | w_wr_set);

  prio_onehot_enc #(
    .NBEAMS (NBEAMS),
    .IDX_W  (c_BEAM_W)
  ) u_prio (
    .req_i    (r_work),
    .idx_o    (w_idx),
    .onehot_o (w_onehot),
    .valid_o  (w_valid)
  );

  assign w_work_rem = r_work & ~w_onehot;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < NBEAMS; b++) begin
        r_shadow[b] <= THRESH_W'(DEFAULT_THRESH);
      end
    end else if (w_wr_hit) begin
      r_shadow[wr_beam_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= IDLE;
      r_dirty        <= '1;
      r_work         <= '0;
      r_init_pending <= AUTO_INIT;
      r_apply_ack    <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_update       <= 1'b0;
      r_thresh       <= '0;
      r_thresh_ce    <= '0;
    end else begin
      r_dirty        <= w_dirty_next;
      r_init_pending <= 1'b0;
      r_apply_ack    <= 1'b0;
      r_done         <= 1'b0;
      r_update       <= 1'b0;
      r_thresh_ce    <= '0;
      // Busy covers LOAD/UPDATE/DONE as seen one cycle later, which places
      // it from the cycle after ack through the done cycle.
      r_busy         <= (r_state != IDLE);

      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_apply_ack <= apply_req_i;
            r_work      <= r_dirty;
            // Nothing to stream: commit on the very next cycle.
            r_state     <= (|r_dirty) ? LOAD : UPDATE;
          end
        end
        LOAD: begin
          if (w_valid) begin
            r_thresh    <= r_shadow[w_idx];
            r_thresh_ce <= w_onehot;
          end
          r_work <= w_work_rem;
          if (w_work_rem == '0) begin
            r_state <= UPDATE;
          end
        end
        UPDATE: begin
          r_update <= 1'b1;
          r_state  <= DONE;
        end
        DONE: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign apply_ack_o = r_apply_ack;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign dirty_o     = r_dirty;
  assign thresh_o    = r_thresh;
  assign thresh_ce_o = r_thresh_ce;
  assign update_o    = r_update;

endmodule : beam_threshold_sequencer
`default_nettype wire

// File: tb/tb_beam_threshold_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_beam_threshold_sequencer
// Description : Directed self-checking bench for beam_threshold_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_beam_threshold_sequencer;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        wr_valid_i = 1'b0;
  logic [2:0]  wr_beam_i = '0;
  logic [17:0] wr_data_i = '0;
  logic        apply_req_i = 1'b0;
  logic        apply_ack_o;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  dirty_o;
  logic [17:0] thresh_o;
  logic [7:0]  thresh_ce_o;
  logic        update_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  beam_threshold_sequencer #(
    .NBEAMS         (8),
    .THRESH_W       (18),
    .DEFAULT_THRESH (9000),
    .AUTO_INIT      (1'b1)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .wr_valid_i  (wr_valid_i),
    .wr_beam_i   (wr_beam_i),
    .wr_data_i   (wr_data_i),
    .apply_req_i (apply_req_i),
    .apply_ack_o (apply_ack_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .dirty_o     (dirty_o),
    .thresh_o    (thresh_o),
    .thresh_ce_o (thresh_ce_o),
    .update_o    (update_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic ack, input logic busy,
                         input logic upd, input logic dn, input logic [7:0] ce);
    chk({tag, ".ack"},  32'(apply_ack_o), 32'(ack));
    chk({tag, ".busy"}, 32'(busy_o),      32'(busy));
    chk({tag, ".upd"},  32'(update_o),    32'(upd));
    chk({tag, ".done"}, 32'(done_o),      32'(dn));
    chk({tag, ".ce"},   32'(thresh_ce_o), 32'(ce));
  endtask

  task automatic wr(input logic [2:0] b, input logic [17:0] d);
    wr_valid_i = 1'b1;
    wr_beam_i  = b;
    wr_data_i  = d;
    tick();
    wr_valid_i = 1'b0;
  endtask

  // At most one load enable may be high in any cycle.
  always @(negedge clk) begin
    if (rst_ni) chk("ce_onehot", 32'($onehot0(thresh_ce_o)), 32'd1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset and auto-init ----------------
    repeat (3) @(posedge clk);
    #1;
    chk_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst.thresh", 32'(thresh_o), 32'd0);
    chk("rst.dirty",  32'(dirty_o),  32'hFF);
    rst_ni = 1'b1;
    tick();
    chk_ctl("init.snap", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("init.dirty", 32'(dirty_o), 32'h00);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_ctl($sformatf("init.ld%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, 8'(1 << i));
      chk($sformatf("init.th%0d", i), 32'(thresh_o), 32'd9000);
    end
    tick(); chk_ctl("init.upd",  1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    tick(); chk_ctl("init.done", 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    tick(); chk_ctl("init.idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("init.dirty_end", 32'(dirty_o), 32'h00);

    // ---------------- two dirty beams ----------------
    wr(3'd3, 18'd12000);
    wr(3'd6, 18'd7000);
    chk("two.dirty", 32'(dirty_o), 32'h48);
    apply_req_i = 1'b1;
    tick(); chk_ctl("two.ack", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("two.dirty_ack", 32'(dirty_o), 32'h00);
    apply_req_i = 1'b0;
    tick(); chk_ctl("two.b3", 1'b0, 1'b1, 1'b0, 1'b0, 8'h08);
    chk("two.th3", 32'(thresh_o), 32'd12000);
    tick(); chk_ctl("two.b6", 1'b0, 1'b1, 1'b0, 1'b0, 8'h40);
    chk("two.th6", 32'(thresh_o), 32'd7000);
    tick(); chk_ctl("two.upd",  1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    tick(); chk_ctl("two.done", 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    tick(); chk_ctl("two.idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("two.th_hold", 32'(thresh_o), 32'd7000);

    // ---------------- apply with nothing dirty ----------------
    apply_req_i = 1'b1;
    tick(); chk_ctl("empty.ack", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    apply_req_i = 1'b0;
    tick(); chk_ctl("empty.upd",  1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    tick(); chk_ctl("empty.done", 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    tick(); chk_ctl("empty.idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("empty.th_hold", 32'(thresh_o), 32'd7000);

    // ---------------- write to an already-streamed beam ----------------
    wr(3'd1, 18'd100);
    wr(3'd2, 18'd200);
    wr(3'd4, 18'd400);
    chk("race.dirty", 32'(dirty_o), 32'h16);
    apply_req_i = 1'b1;
    tick(); chk_ctl("race.ack", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    apply_req_i = 1'b0;
    tick(); chk_ctl("race.b1", 1'b0, 1'b1, 1'b0, 1'b0, 8'h02);
    chk("race.th1", 32'(thresh_o), 32'd100);
    tick(); chk_ctl("race.b2", 1'b0, 1'b1, 1'b0, 1'b0, 8'h04);
    chk("race.th2", 32'(thresh_o), 32'd200);
    wr_valid_i = 1'b1; wr_beam_i = 3'd2; wr_data_i = 18'd555;
    tick(); chk_ctl("race.b4", 1'b0, 1'b1, 1'b0, 1'b0, 8'h10);
    chk("race.th4", 32'(thresh_o), 32'd400);
    wr_valid_i = 1'b0;
    tick(); chk_ctl("race.upd",  1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    tick(); chk_ctl("race.done", 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    tick(); chk("race.dirty_end", 32'(dirty_o), 32'h04);
    apply_req_i = 1'b1;
    tick(); chk_ctl("race2.ack", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    apply_req_i = 1'b0;
    tick(); chk_ctl("race2.b2", 1'b0, 1'b1, 1'b0, 1'b0, 8'h04);
    chk("race2.th2", 32'(thresh_o), 32'd555);
    tick(); chk_ctl("race2.upd",  1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    tick(); chk_ctl("race2.done", 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    tick();

    // ---------------- write on the snapshot edge ----------------
    wr(3'd1, 18'd1111);
    chk("snap.dirty", 32'(dirty_o), 32'h02);
    apply_req_i = 1'b1;
    wr_valid_i = 1'b1; wr_beam_i = 3'd5; wr_data_i = 18'd5555;
    tick(); chk_ctl("snap.ack", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("snap.dirty_ack", 32'(dirty_o), 32'h20);
    apply_req_i = 1'b0;
    wr_valid_i = 1'b0;
    tick(); chk_ctl("snap.b1", 1'b0, 1'b1, 1'b0, 1'b0, 8'h02);
    chk("snap.th1", 32'(thresh_o), 32'd1111);
    tick(); chk_ctl("snap.upd",  1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    tick(); chk_ctl("snap.done", 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    tick(); chk_ctl("snap.idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("snap.dirty_end", 32'(dirty_o), 32'h20);

    // ---------------- reset mid-LOAD ----------------
    wr(3'd0, 18'd10);
    wr(3'd7, 18'd70);
    chk("abort.dirty", 32'(dirty_o), 32'hA1);
    apply_req_i = 1'b1;
    tick(); chk_ctl("abort.ack", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    apply_req_i = 1'b0;
    tick(); chk_ctl("abort.b0", 1'b0, 1'b1, 1'b0, 1'b0, 8'h01);
    chk("abort.th0", 32'(thresh_o), 32'd10);
    rst_ni = 1'b0;
    #1;
    chk_ctl("abort.rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("abort.thresh", 32'(thresh_o), 32'd0);
    chk("abort.dirty_rst", 32'(dirty_o), 32'hFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("abort.no_upd%0d", i), 32'(update_o), 32'd0);
    end
    rst_ni = 1'b1;
    tick(); chk("abort.snap_dirty", 32'(dirty_o), 32'h00);
    tick(); chk_ctl("abort.reinit_b0", 1'b0, 1'b1, 1'b0, 1'b0, 8'h01);
    chk("abort.reinit_th0", 32'(thresh_o), 32'd9000);
    for (int i = 0; i < 20 && !done_o; i++) tick();
    chk("abort.done_seen", 32'(done_o), 32'd1);
    tick();
    chk("abort.busy_end", 32'(busy_o), 32'd0);
    chk("abort.dirty_end", 32'(dirty_o), 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_beam_threshold_sequencer
`default_nettype wire
